// File: rtl/servo_pwm_scheduler_pkg.sv
// Shared constants, timebase state type and sizing helpers for the servo PWM scheduler.
// Default timing gives a 20 ms frame with a 1 ms pulse floor at 100 MHz.
package servo_pwm_scheduler_pkg;

    localparam int IDX_W            = 5;
    localparam int DEF_NUM_SERVOS   = 18;
    localparam int DEF_FXP_WIDTH    = 20;
    localparam int DEF_PWM_OFFSET   = 8;
    localparam int DEF_PWM_WIDTH    = 8;
    localparam int DEF_PRESCALE     = 390;
    localparam int DEF_PERIOD_TICKS = 5120;
    localparam int DEF_MIN_TICKS    = 256;

    typedef enum logic {
        TB_IDLE = 1'b0,
        TB_RUN  = 1'b1
    } tb_state_e;

    // Counter width for a modulus of n (never below one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // LSB position of the duty slice inside an angle word.
    function automatic int duty_lsb(input int offset, input int width);
        return offset - width + 1;
    endfunction

endpackage

// File: rtl/servo_pwm_scheduler_if.sv
// Angle stream from the inverse-kinematics engine: one joint angle per beat,
// LAST marks the final word of a set and requests a commit.
interface servo_pwm_scheduler_if
    import servo_pwm_scheduler_pkg::*;
#(
    parameter int FXP_WIDTH = DEF_FXP_WIDTH
) ();

    logic                 ANGLE_VALID;
    logic                 ANGLE_READY;
    logic [FXP_WIDTH-1:0] ANGLE_DATA;
    logic [IDX_W-1:0]     ANGLE_IDX;
    logic                 ANGLE_LAST;

    modport master (
        output ANGLE_VALID,
        output ANGLE_DATA,
        output ANGLE_IDX,
        output ANGLE_LAST,
        input  ANGLE_READY
    );

    modport slave (
        input  ANGLE_VALID,
        input  ANGLE_DATA,
        input  ANGLE_IDX,
        input  ANGLE_LAST,
        output ANGLE_READY
    );

endinterface

// File: rtl/servo_pwm_scheduler_timebase.sv
// Shared prescaler and frame counter; ENABLE is only honoured at frame boundaries.
//   state   | meaning
//   TB_IDLE | counters held at 0, no frames, outputs gated off
//   TB_RUN  | prescaler/tick counter advancing, FRAME_START at each (0,0)
module servo_pwm_timebase
    import servo_pwm_scheduler_pkg::*;
#(
    parameter int PRESCALE     = DEF_PRESCALE,
    parameter int PERIOD_TICKS = DEF_PERIOD_TICKS
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                enable,
    output logic                                run,
    output logic [cnt_width(PERIOD_TICKS)-1:0]  tick_cnt,
    output logic                                frame_start
);

    localparam int PRESC_W = cnt_width(PRESCALE);
    localparam int TICK_W  = cnt_width(PERIOD_TICKS);

    tb_state_e           state, state_nxt;
    logic [PRESC_W-1:0]  presc, presc_nxt;
    logic [TICK_W-1:0]   tick_nxt;
    logic                fs_nxt;
    logic                presc_last;
    logic                tick_last;

    assign presc_last = (presc == PRESC_W'(PRESCALE - 1));
    assign tick_last  = (tick_cnt == TICK_W'(PERIOD_TICKS - 1));
    assign run        = (state == TB_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= TB_IDLE;
            presc       <= '0;
            tick_cnt    <= '0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nxt;
            presc       <= presc_nxt;
            tick_cnt    <= tick_nxt;
            frame_start <= fs_nxt;
        end
    end

    // frame_start is registered so it lines up with the (0,0) counter state it announces.
    always_comb begin
        state_nxt = state;
        presc_nxt = presc;
        tick_nxt  = tick_cnt;
        fs_nxt    = 1'b0;
        case (state)
            TB_IDLE: begin
                presc_nxt = '0;
                tick_nxt  = '0;
                if (enable) begin
                    state_nxt = TB_RUN;
                    fs_nxt    = 1'b1;
                end
            end
            TB_RUN: begin
                if (presc_last) begin
                    presc_nxt = '0;
                    if (tick_last) begin
                        tick_nxt = '0;
                        if (enable) begin
                            fs_nxt = 1'b1;
                        end else begin
                            state_nxt = TB_IDLE;
                        end
                    end else begin
                        tick_nxt = tick_cnt + 1'b1;
                    end
                end else begin
                    presc_nxt = presc + 1'b1;
                end
            end
            default: begin
                state_nxt = TB_IDLE;
                presc_nxt = '0;
                tick_nxt  = '0;
            end
        endcase
    end

endmodule

// File: rtl/servo_pwm_scheduler.sv
// Hexapod servo PWM scheduler: stages IK joint angles, commits the whole set at a
// frame boundary and drives NUM_SERVOS synchronous pulse outputs.
module servo_pwm_scheduler
    import servo_pwm_scheduler_pkg::*;
#(
    parameter int NUM_SERVOS   = DEF_NUM_SERVOS,
    parameter int FXP_WIDTH    = DEF_FXP_WIDTH,
    parameter int PWM_OFFSET   = DEF_PWM_OFFSET,
    parameter int PWM_WIDTH    = DEF_PWM_WIDTH,
    parameter int PRESCALE     = DEF_PRESCALE,
    parameter int PERIOD_TICKS = DEF_PERIOD_TICKS,
    parameter int MIN_TICKS    = DEF_MIN_TICKS
) (
    input  logic                   CLK,
    input  logic                   RESETN,
    input  logic                   ENABLE,
    servo_pwm_scheduler_if.slave   angle,
    output logic [NUM_SERVOS-1:0]  PWM_OUT,
    output logic                   FRAME_START,
    output logic                   COMMIT_DONE,
    output logic                   IDX_ERR
);

    localparam int TICK_W = cnt_width(PERIOD_TICKS);
    localparam int CMP_W  = TICK_W + 1;

    logic [FXP_WIDTH-1:0] data;
    logic [PWM_WIDTH-1:0] duty_in;
    logic                 unused_data;
    logic                 accept;
    logic                 idx_ok;
    logic                 commit;
    logic                 pending;
    logic                 pending_nxt;
    logic                 ready;
    logic                 idx_err;
    logic                 run;
    logic                 frame_start;
    logic [TICK_W-1:0]    tick_cnt;

    assign data        = angle.ANGLE_DATA;
    assign duty_in     = data[PWM_OFFSET -: PWM_WIDTH];
    assign unused_data = ^data;

    assign accept = angle.ANGLE_VALID & ready;
    assign idx_ok = (32'(angle.ANGLE_IDX) < $unsigned(32'(NUM_SERVOS)));
    assign commit = frame_start & pending;

    assign angle.ANGLE_READY = ready;
    assign FRAME_START       = frame_start;
    assign COMMIT_DONE       = commit;
    assign IDX_ERR           = idx_err;

    // commit and LAST-accept cannot coincide: commit needs pending, which holds ready low.
    always_comb begin
        pending_nxt = pending;
        if (commit) begin
            pending_nxt = 1'b0;
        end else if (accept && angle.ANGLE_LAST) begin
            pending_nxt = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            pending <= 1'b0;
            ready   <= 1'b0;
            idx_err <= 1'b0;
        end else begin
            pending <= pending_nxt;
            ready   <= !pending_nxt;
            if (accept && !idx_ok) begin
                idx_err <= 1'b1;
            end
        end
    end

    servo_pwm_timebase #(
        .PRESCALE     (PRESCALE),
        .PERIOD_TICKS (PERIOD_TICKS)
    ) u_timebase (
        .clk         (CLK),
        .rst_n       (RESETN),
        .enable      (ENABLE),
        .run         (run),
        .tick_cnt    (tick_cnt),
        .frame_start (frame_start)
    );

    for (genvar i = 0; i < NUM_SERVOS; i++) begin : g_ch
        logic [PWM_WIDTH-1:0] staged;
        logic [PWM_WIDTH-1:0] active;
        logic [PWM_WIDTH-1:0] duty_eff;
        logic [CMP_W-1:0]     thresh;
        logic                 pwm;

        // Compare against the incoming set during the commit cycle so the new duty owns this frame.
        assign duty_eff = commit ? staged : active;
        assign thresh   = CMP_W'(MIN_TICKS) + CMP_W'(duty_eff);

        always_ff @(posedge CLK or negedge RESETN) begin
            if (!RESETN) begin
                staged <= '0;
                active <= '0;
                pwm    <= 1'b0;
            end else begin
                if (accept && (angle.ANGLE_IDX == IDX_W'(i))) begin
                    staged <= duty_in;
                end
                if (commit) begin
                    active <= staged;
                end
                pwm <= run && ({1'b0, tick_cnt} < thresh);
            end
        end

        assign PWM_OUT[i] = pwm;
    end

endmodule

// File: tb/tb_servo_pwm_scheduler.sv
// Directed-plus-random bench for servo_pwm_scheduler with a cycle-level pulse-width model.
module tb_servo_pwm_scheduler;

    localparam int NS   = 3;
    localparam int FXP  = 20;
    localparam int OFF  = 4;
    localparam int PW   = 4;
    localparam int PRE  = 2;
    localparam int PER  = 64;
    localparam int MINT = 4;
    localparam int FRAME_CLKS = PER * PRE;

    logic          CLK;
    logic          RESETN;
    logic          ENABLE;
    logic [NS-1:0] pwm;
    logic          fs;
    logic          cdone;
    logic          ierr;

    servo_pwm_scheduler_if #(.FXP_WIDTH(FXP)) angle_bus ();

    servo_pwm_scheduler #(
        .NUM_SERVOS   (NS),
        .FXP_WIDTH    (FXP),
        .PWM_OFFSET   (OFF),
        .PWM_WIDTH    (PW),
        .PRESCALE     (PRE),
        .PERIOD_TICKS (PER),
        .MIN_TICKS    (MINT)
    ) dut (
        .CLK         (CLK),
        .RESETN      (RESETN),
        .ENABLE      (ENABLE),
        .angle       (angle_bus),
        .PWM_OUT     (pwm),
        .FRAME_START (fs),
        .COMMIT_DONE (cdone),
        .IDX_ERR     (ierr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp;
    int n_fail;

    // Reference model: staged/active duty codes, pending flag, sticky index error.
    int m_stg [NS];
    int m_act [NS];
    bit m_pend;
    bit m_err;
    int meas_len;
    int meas_w [NS];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    function automatic int slice_of(input logic [FXP-1:0] d);
        return (int'(d) / (1 << (OFF - PW + 1))) % (1 << PW);
    endfunction

    function automatic int width_of(input int ch);
        return (MINT + m_act[ch]) * PRE;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_stg[i] = 0;
            m_act[i] = 0;
        end
        m_pend = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic model_accept(input int idx, input logic [FXP-1:0] d, input bit last);
        if (idx < NS) m_stg[idx] = slice_of(d);
        else          m_err = 1'b1;
        if (last)     m_pend = 1'b1;
    endtask

    // Called at the negedge of a FRAME_START cycle.
    task automatic on_fs(input string tag);
        check({tag, "_commit"}, cdone, m_pend);
        if (m_pend) begin
            for (int i = 0; i < NS; i++) m_act[i] = m_stg[i];
            m_pend = 1'b0;
        end
    endtask

    task automatic wait_fs(input string tag);
        int n;
        n = 0;
        while (!fs && n < 400) begin
            tick();
            n++;
        end
        check({tag, "_fs_seen"}, fs, 1'b1);
        if (fs) on_fs(tag);
    endtask

    task automatic send(input int idx, input logic [FXP-1:0] d, input bit last);
        int n;
        angle_bus.ANGLE_VALID = 1'b1;
        angle_bus.ANGLE_IDX   = 5'(idx);
        angle_bus.ANGLE_DATA  = d;
        angle_bus.ANGLE_LAST  = last;
        n = 0;
        while (!angle_bus.ANGLE_READY && n < 400) begin
            tick();
            n++;
        end
        check("send_ready", angle_bus.ANGLE_READY, 1'b1);
        tick();
        angle_bus.ANGLE_VALID = 1'b0;
        angle_bus.ANGLE_LAST  = 1'b0;
        model_accept(idx, d, last);
    endtask

    // Starts on a FRAME_START negedge, returns on the next one.
    task automatic measure_frame(input string tag);
        for (int i = 0; i < NS; i++) meas_w[i] = int'(pwm[i]);
        meas_len = FRAME_CLKS + 400;
        for (int c = 1; c < FRAME_CLKS + 400; c++) begin
            tick();
            if (fs) begin
                meas_len = c;
                break;
            end
            for (int i = 0; i < NS; i++) meas_w[i] += int'(pwm[i]);
        end
        check({tag, "_frame_len"}, meas_len, FRAME_CLKS);
        for (int i = 0; i < NS; i++) begin
            check($sformatf("%s_width%0d", tag, i), meas_w[i], width_of(i));
        end
    endtask

    function automatic logic [FXP-1:0] data_with_slice(input int s);
        logic [FXP-1:0] d;
        d = FXP'($urandom);
        d[OFF -: PW] = PW'(s);
        return d;
    endfunction

    initial begin
        int held_idx;
        logic [FXP-1:0] held_data;
        int n;
        bit stall_bad;
        int fs_cnt;
        int s_bad;
        logic [NS-1:0] exp_mask;

        n_cmp  = 0;
        n_fail = 0;
        RESETN = 1'b0;
        ENABLE = 1'b0;
        angle_bus.ANGLE_VALID = 1'b0;
        angle_bus.ANGLE_IDX   = '0;
        angle_bus.ANGLE_DATA  = '0;
        angle_bus.ANGLE_LAST  = 1'b0;
        model_reset();

        // Reset defaults
        repeat (5) tick();
        check("rst_pwm", pwm, '0);
        check("rst_fs", fs, 1'b0);
        check("rst_commit", cdone, 1'b0);
        check("rst_idx_err", ierr, 1'b0);
        check("rst_ready", angle_bus.ANGLE_READY, 1'b0);
        RESETN = 1'b1;
        check("ready_before_edge", angle_bus.ANGLE_READY, 1'b0);
        tick();
        check("ready_after_release", angle_bus.ANGLE_READY, 1'b1);
        check("idle_pwm", pwm, '0);

        // Slice and width
        send(0, 20'h000A0, 1'b0);
        send(1, 20'h0001E, 1'b0);
        send(2, 20'h00006, 1'b1);
        check("ready_low_after_last", angle_bus.ANGLE_READY, 1'b0);
        repeat (3) tick();
        check("no_fs_when_disabled", fs, 1'b0);
        ENABLE = 1'b1;
        tick();
        check("fs_on_enable", fs, 1'b1);
        check("slice_commit_lit", cdone, 1'b1);
        on_fs("slice");
        measure_frame("slice");
        check("slice_w0_lit", meas_w[0], 8);
        check("slice_w1_lit", meas_w[1], 38);
        check("slice_w2_lit", meas_w[2], 14);

        // Backpressure: hold VALID behind a pending set
        on_fs("bp0");
        for (int i = 0; i < NS; i++) send(i, FXP'($urandom), i == NS - 1);
        held_idx  = ($urandom_range(0, 1) == 0) ? 0 : 2;
        held_data = FXP'($urandom);
        angle_bus.ANGLE_VALID = 1'b1;
        angle_bus.ANGLE_IDX   = 5'(held_idx);
        angle_bus.ANGLE_DATA  = held_data;
        angle_bus.ANGLE_LAST  = 1'b0;
        stall_bad = 1'b0;
        n = 0;
        tick();
        while (!fs && n < 400) begin
            if (angle_bus.ANGLE_READY) stall_bad = 1'b1;
            tick();
            n++;
        end
        check("bp_ready_low", stall_bad, 1'b0);
        check("bp_fs_seen", fs, 1'b1);
        check("bp_ready_at_commit", angle_bus.ANGLE_READY, 1'b0);
        on_fs("bp");
        tick();
        check("bp_ready_after_commit", angle_bus.ANGLE_READY, 1'b1);
        tick();
        angle_bus.ANGLE_VALID = 1'b0;
        model_accept(held_idx, held_data, 1'b0);
        send(1, data_with_slice($urandom_range(8, 15)), 1'b1);
        wait_fs("held");
        measure_frame("held");

        // Bad index: dropped data, sticky error, LAST still commits
        on_fs("bad0");
        s_bad = 0;
        for (int v = 0; v < (1 << PW); v++) begin
            if (v != m_stg[0] && v != m_stg[1] && v != m_stg[2]) begin
                s_bad = v;
                break;
            end
        end
        send(5, data_with_slice(s_bad), 1'b1);
        check("bad_idx_err", ierr, m_err);
        check("bad_ready_low", angle_bus.ANGLE_READY, 1'b0);
        wait_fs("bad");
        measure_frame("bad");
        check("idx_err_sticky", ierr, 1'b1);

        // ENABLE drop at tick 10: frame completes, then silence
        on_fs("dis0");
        fs_cnt = 0;
        for (int i = 0; i < NS; i++) meas_w[i] = int'(pwm[i]);
        for (int c = 1; c < FRAME_CLKS + 200; c++) begin
            tick();
            if (c == 20) ENABLE = 1'b0;
            if (fs) fs_cnt++;
            for (int i = 0; i < NS; i++) meas_w[i] += int'(pwm[i]);
        end
        check("dis_no_fs", fs_cnt, 0);
        for (int i = 0; i < NS; i++) check($sformatf("dis_width%0d", i), meas_w[i], width_of(i));
        check("dis_pwm_low", pwm, '0);

        // Pending persists while disabled; re-enable starts a frame next clock
        send(0, FXP'($urandom), 1'b0);
        send(1, data_with_slice($urandom_range(8, 15)), 1'b0);
        send(2, FXP'($urandom), 1'b1);
        repeat (5) tick();
        check("dis_pending_ready", angle_bus.ANGLE_READY, 1'b0);
        check("dis_idle_fs", fs, 1'b0);
        ENABLE = 1'b1;
        tick();
        check("reen_fs", fs, 1'b1);
        on_fs("reen");
        measure_frame("reen");

        // Async reset at tick 6 with a pending set
        on_fs("rst0");
        tick();
        send($urandom_range(0, NS - 1), FXP'($urandom), 1'b1);
        repeat (10) tick();
        for (int i = 0; i < NS; i++) exp_mask[i] = (12 <= width_of(i));
        check("pre_rst_pwm", pwm, exp_mask);
        #2;
        RESETN = 1'b0;
        #1;
        check("async_rst_pwm", pwm, '0);
        check("async_rst_ready", angle_bus.ANGLE_READY, 1'b0);
        check("async_rst_fs", fs, 1'b0);
        model_reset();
        repeat (3) tick();
        RESETN = 1'b1;
        tick();
        check("post_rst_ready", angle_bus.ANGLE_READY, 1'b1);
        check("post_rst_idx_err", ierr, m_err);
        check("post_rst_fs", fs, 1'b1);
        check("post_rst_pwm", pwm, '0);
        on_fs("post_rst");
        measure_frame("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/servo_pwm_scheduler.md
Name: servo_pwm_scheduler

Overview:
- Bridges the inverse-kinematics engine to the hexapod servos.
- Accepts a set of NUM_SERVOS joint angles in fixed point over a valid/ready stream and slices each into a PWM_WIDTH duty code.
- Double-buffers the set so that all servos change together at a frame boundary.
- Generates NUM_SERVOS synchronous servo PWM waveforms from a shared prescaler and frame counter.

Parameters:
- NUM_SERVOS, 18, number of servo channels (6 legs x 3 joints).
- FXP_WIDTH, 20, width of incoming fixed-point angle.
- PWM_OFFSET, 8, MSB index of duty slice within the angle word.
- PWM_WIDTH, 8, duty code width.
- PRESCALE, 390, CLK cycles per PWM tick (must be >=1).
- PERIOD_TICKS, 5120, ticks per PWM frame (20 ms at 100 MHz).
- MIN_TICKS, 256, fixed pulse floor in ticks (1 ms); requires MIN_TICKS + 2^PWM_WIDTH - 1 < PERIOD_TICKS.

Ports:
- CLK  in  1  system clock.
- RESETN  in  1  asynchronous active-low reset.
- ENABLE  in  1  1 = run frames; 0 = hold all PWM low, counters cleared at next frame end.
- ANGLE_VALID  in  1  angle word valid.
- ANGLE_READY  out  1  block can accept angle word.
- ANGLE_DATA  in  FXP_WIDTH  joint angle, fixed point.
- ANGLE_IDX  in  5  servo index 0..NUM_SERVOS-1.
- ANGLE_LAST  in  1  marks final word of a set; requests commit.
- PWM_OUT  out  NUM_SERVOS  servo pulse outputs, bit i = servo i.
- FRAME_START  out  1  one-cycle pulse on first clock of each frame.
- COMMIT_DONE  out  1  one-cycle pulse when staged set copied to active.
- IDX_ERR  out  1  sticky; set on accepted word with ANGLE_IDX >= NUM_SERVOS, cleared only by reset.

Behaviour:
- Reset (async, RESETN=0): PWM_OUT=0, FRAME_START=0, COMMIT_DONE=0, IDX_ERR=0, ANGLE_READY=0. Staging and active duty registers = 0. Prescaler, tick counter and pending flag = 0. ANGLE_READY rises on the first clock after reset release.
- Duty slice: duty = ANGLE_DATA[PWM_OFFSET -: PWM_WIDTH], i.e. bits [8:1] with defaults. Truncate only, no rounding or saturation.
- Accept: a word is accepted on a clock edge with ANGLE_VALID & ANGLE_READY.
  - Valid index: write the slice to staging[ANGLE_IDX].
  - Invalid index: drop the data and set IDX_ERR.
  - Unwritten staging entries keep their previous value.
- Pending: an accepted word with ANGLE_LAST=1 sets pending (data is still written if the index is valid). ANGLE_READY = !pending; it deasserts the cycle after LAST is accepted.
- Commit: on the FRAME_START cycle, if pending=1, copy active <= staging, clear pending and pulse COMMIT_DONE the same cycle. ANGLE_READY returns to 1 the next cycle. The new duties take effect in this same frame.
- Timing: the prescaler counts 0..PRESCALE-1 and emits tick at PRESCALE-1. The tick counter counts 0..PERIOD_TICKS-1 on each tick, then wraps. FRAME_START = (tick_cnt==0 & presc==0 & ENABLE).
- Output: PWM_OUT[i] = ENABLE_run & (tick_cnt < MIN_TICKS + active[i]), registered (1-cycle latency from counter state). Pulse width = (MIN_TICKS + duty) * PRESCALE clocks.
- ENABLE: sampled at frame boundaries.
  - ENABLE deasserted mid-frame: finish the current frame, then hold counters at 0 and PWM_OUT low.
  - ENABLE asserted while idle: frame starts on the next clock.
  - Commit occurs only at FRAME_START, so pending persists while disabled.
- Simultaneous events:
  - LAST accepted on the FRAME_START cycle: the word is written to staging and pending is set, but no commit occurs until the next frame.
  - ANGLE_READY=0 on that cycle can only arise from an older pending; in that case the commit clears pending.
- Reset mid-frame: all outputs low immediately; no partial pulse after release.

Decomposition:
- Shared package/header: NUM_SERVOS, IDX width (5), default PWM timing constants, duty slice macro/function.
- Natural sub-module: servo_pwm_timebase (prescaler + frame counter + FRAME_START/ENABLE gating).
- Per-channel compares are generated inline in a generate loop.

Test Plan:
- Reset/defaults: hold RESETN=0 for 5 clocks, then release. Expect all outputs 0 and ANGLE_READY=1 after 1 clock.
  - Test params: PRESCALE=2, PERIOD_TICKS=64, MIN_TICKS=4, PWM_WIDTH=4, PWM_OFFSET=4, NUM_SERVOS=3.
- Slice and width: write idx0 data 0x000A0 (bits[4:1]=0), idx1 0x0001E (=0xF), idx2 0x00006 with LAST.
  - Expect COMMIT_DONE at next FRAME_START.
  - Expect PWM high for 8, 38 and 14 clocks respectively; frame length 128 clocks.
- Backpressure: send a LAST word, then hold VALID. Expect ANGLE_READY=0 until the COMMIT_DONE cycle, and 1 on the next cycle; no data lost.
- Bad index: write idx 5 -> IDX_ERR=1 sticky, staging unchanged, and the LAST on that word still commits.
- ENABLE drop mid-frame at tick 10: frame completes, then PWM_OUT stays 0 with no FRAME_START. Re-enable -> FRAME_START on the next clock.
- Async reset at tick 6 with PWM high: PWM_OUT goes 0 without waiting for a CLK edge; after release, active duties are 0 and pending is cleared.
